// File: rtl/sdr_wb_pkg.sv
// Shared types and constants for the Wishbone-to-SDRAM request bridge.
package sdr_wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WDATA,
        RDATA,
        DONE,
        ERR
    } wb_br_state_t;

    localparam logic [8:0] APP_LEN_SINGLE = 9'd1;

endpackage

// File: rtl/wb_br_timeout.sv
// Transaction watchdog: counts enabled cycles and flags the last allowed one.
module wb_br_timeout #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Asserted during the final cycle the transaction is allowed to stay busy
    assign expire_c = en && (cnt == LAST);

endmodule

// File: rtl/wb_sdr_req_bridge.sv
// Wishbone B3 classic slave turning single-beat accesses into SDRAM core
// app requests, with a bounded-latency error termination.
module wb_sdr_req_bridge
    import sdr_wb_pkg::*;
#(
    parameter int unsigned WB_AW   = 26,
    parameter int unsigned WB_DW   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [WB_AW-1:0]      wb_adr_i,
    input  logic [WB_DW/8-1:0]    wb_sel_i,
    input  logic [WB_DW-1:0]      wb_dat_i,
    output logic [WB_DW-1:0]      wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    input  logic                  sdr_init_done,
    output logic                  app_req,
    output logic [WB_AW-3:0]      app_req_addr,
    output logic [8:0]            app_req_len,
    output logic                  app_req_wr_n,
    input  logic                  app_req_ack,
    output logic [WB_DW/8-1:0]    app_wr_en_n,
    output logic [WB_DW-1:0]      app_wr_data,
    input  logic                  app_wr_next,
    input  logic [WB_DW-1:0]      app_rd_data,
    input  logic                  app_rd_valid
);

    localparam int unsigned SW  = WB_DW / 8;
    localparam int unsigned RAW = WB_AW - 2;

    wb_br_state_t     state_q;
    wb_br_state_t     state_d;
    logic             ack_d;
    logic             err_d;
    logic             req_d;
    logic             wr_n_d;
    logic [RAW-1:0]   addr_d;
    logic [SW-1:0]    en_n_d;
    logic [WB_DW-1:0] wr_data_d;
    logic [WB_DW-1:0] dat_d;
    logic             cyc_stb;
    logic             busy;
    logic             expire_c;
    logic             unused_adr_lsb;

    assign cyc_stb     = wb_cyc_i & wb_stb_i;
    assign busy        = (state_q == REQ) || (state_q == WDATA) || (state_q == RDATA);
    assign app_req_len = APP_LEN_SINGLE;

    // Byte addressing below word granularity is carried by wb_sel_i alone
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    wb_br_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .en       (busy),
        .clr      (!busy),
        .expire_c (expire_c)
    );

    // Next-state and next-output logic; terminations register in the same edge
    // that enters DONE/ERR so ack/err appear one cycle after the core event.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        req_d     = app_req;
        wr_n_d    = app_req_wr_n;
        addr_d    = app_req_addr;
        en_n_d    = app_wr_en_n;
        wr_data_d = app_wr_data;
        dat_d     = wb_dat_o;

        case (state_q)
            IDLE: begin
                if (cyc_stb && sdr_init_done) begin
                    addr_d    = wb_adr_i[WB_AW-1:2];
                    wr_n_d    = !wb_we_i;
                    en_n_d    = ~wb_sel_i;
                    wr_data_d = wb_dat_i;
                    req_d     = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (expire_c) begin
                    req_d   = 1'b0;
                    err_d   = cyc_stb;
                    state_d = ERR;
                end else if (app_req_ack) begin
                    req_d   = 1'b0;
                    state_d = app_req_wr_n ? RDATA : WDATA;
                end
            end
            WDATA: begin
                if (expire_c) begin
                    err_d   = cyc_stb;
                    state_d = ERR;
                end else if (app_wr_next) begin
                    ack_d   = cyc_stb;
                    state_d = DONE;
                end
            end
            RDATA: begin
                if (expire_c) begin
                    err_d   = cyc_stb;
                    state_d = ERR;
                end else if (app_rd_valid) begin
                    dat_d   = app_rd_data;
                    ack_d   = cyc_stb;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_dat_o     <= '0;
            app_req      <= 1'b0;
            app_req_addr <= '0;
            app_req_wr_n <= 1'b1;
            app_wr_en_n  <= '1;
            app_wr_data  <= '0;
        end else begin
            state_q      <= state_d;
            wb_ack_o     <= ack_d;
            wb_err_o     <= err_d;
            wb_dat_o     <= dat_d;
            app_req      <= req_d;
            app_req_addr <= addr_d;
            app_req_wr_n <= wr_n_d;
            app_wr_en_n  <= en_n_d;
            app_wr_data  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_wb_sdr_req_bridge.sv
// Scoreboard bench for wb_sdr_req_bridge: directed corner cases plus random traffic.
module tb_wb_sdr_req_bridge;

    localparam int unsigned AW  = 26;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [25:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        sdr_init_done;
    logic        app_req;
    logic [23:0] app_req_addr;
    logic [8:0]  app_req_len;
    logic        app_req_wr_n, app_req_ack;
    logic [3:0]  app_wr_en_n;
    logic [31:0] app_wr_data, app_rd_data;
    logic        app_wr_next, app_rd_valid;

    typedef struct {
        logic [23:0] addr;
        logic        wr_n;
        logic [3:0]  en_n;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic        is_err;
        logic        is_rd;
        logic [31:0] data;
        int unsigned at;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int unsigned cyc_n = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_term = 0;
    int          rst_cnt = 0;
    bit          core_en = 1'b1;
    int          fix_ack_dly = -1;
    int          fix_data_dly = -1;
    bit          use_fix_rd = 1'b0;
    logic [31:0] fix_rd_data = '0;

    wb_sdr_req_bridge #(
        .WB_AW   (AW),
        .WB_DW   (DW),
        .TIMEOUT (TMO)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (wb_rst_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_we_i       (wb_we_i),
        .wb_adr_i      (wb_adr_i),
        .wb_sel_i      (wb_sel_i),
        .wb_dat_i      (wb_dat_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .wb_err_o      (wb_err_o),
        .sdr_init_done (sdr_init_done),
        .app_req       (app_req),
        .app_req_addr  (app_req_addr),
        .app_req_len   (app_req_len),
        .app_req_wr_n  (app_req_wr_n),
        .app_req_ack   (app_req_ack),
        .app_wr_en_n   (app_wr_en_n),
        .app_wr_data   (app_wr_data),
        .app_wr_next   (app_wr_next),
        .app_rd_data   (app_rd_data),
        .app_rd_valid  (app_rd_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endfunction

    task automatic check_reset(input string t);
        chk({t, "_ack"},     64'(wb_ack_o),     64'(0));
        chk({t, "_err"},     64'(wb_err_o),     64'(0));
        chk({t, "_dat"},     64'(wb_dat_o),     64'(0));
        chk({t, "_req"},     64'(app_req),      64'(0));
        chk({t, "_addr"},    64'(app_req_addr), 64'(0));
        chk({t, "_wr_n"},    64'(app_req_wr_n), 64'(1));
        chk({t, "_en_n"},    64'(app_wr_en_n),  64'(4'hF));
        chk({t, "_wr_data"}, 64'(app_wr_data),  64'(0));
    endtask

    task automatic wb_start(input logic w, input logic [25:0] a, input logic [3:0] s,
                            input logic [31:0] d, input bit expect_req);
        req_t r;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
        wb_adr_i = a; wb_sel_i = s; wb_dat_i = d;
        if (expect_req) begin
            r.addr = 24'(a / 4);
            r.wr_n = !w;
            r.en_n = ~s;
            r.data = d;
            req_q.push_back(r);
        end
    endtask

    task automatic wb_wait_term();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wb_ack_o || wb_err_o) && n < 200);
        if (!(wb_ack_o || wb_err_o)) chk("term_wait", 64'(0), 64'(1));
    endtask

    task automatic wb_end();
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic wait_req_accepted();
        int n = 0;
        while (!app_req && n < 50) begin @(negedge clk); n++; end
        while (app_req && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("req_accept_wait", 64'(0), 64'(1));
    endtask

    // SDRAM core model: acks the request, then delivers write-consume or read data
    task automatic serve();
        req_t        e;
        bit          have_e;
        logic        wr_n;
        int          d;
        int          epoch;
        logic [31:0] rd;
        epoch  = rst_cnt;
        have_e = (req_q.size() != 0);
        if (!have_e) begin
            chk("unexpected_req", 64'(1), 64'(0));
            wr_n = app_req_wr_n;
        end else begin
            e = req_q.pop_front();
            wr_n = e.wr_n;
            chk("req_addr", 64'(app_req_addr), 64'(e.addr));
            chk("req_wr_n", 64'(app_req_wr_n), 64'(e.wr_n));
            chk("req_len",  64'(app_req_len),  64'(1));
        end
        d = (fix_ack_dly >= 0) ? fix_ack_dly : int'($urandom_range(3));
        repeat (d) @(negedge clk);
        chk("req_held", 64'(app_req), 64'(1));
        app_req_ack = 1'b1;
        @(negedge clk);
        app_req_ack = 1'b0;
        chk("req_drop", 64'(app_req), 64'(0));
        d = (fix_data_dly >= 0) ? fix_data_dly : int'($urandom_range(3));
        repeat (d) @(negedge clk);
        if (!wr_n) begin
            if (have_e && epoch == rst_cnt) begin
                chk("wr_data", 64'(app_wr_data), 64'(e.data));
                chk("wr_en_n", 64'(app_wr_en_n), 64'(e.en_n));
            end
            app_wr_next = 1'b1;
            if (wb_cyc_i && wb_stb_i && epoch == rst_cnt)
                rsp_q.push_back('{1'b0, 1'b0, 32'h0, cyc_n + 1});
            @(negedge clk);
            app_wr_next = 1'b0;
        end else begin
            rd = use_fix_rd ? fix_rd_data : $urandom;
            app_rd_data  = rd;
            app_rd_valid = 1'b1;
            if (wb_cyc_i && wb_stb_i && epoch == rst_cnt)
                rsp_q.push_back('{1'b0, 1'b1, rd, cyc_n + 1});
            @(negedge clk);
            app_rd_valid = 1'b0;
            app_rd_data  = $urandom;
        end
    endtask

    initial begin
        app_req_ack = 1'b0; app_wr_next = 1'b0; app_rd_valid = 1'b0; app_rd_data = '0;
        forever begin
            @(negedge clk);
            if (core_en && app_req && !wb_rst_i) serve();
        end
    end

    // Monitor: every ack/err must match the oldest expected termination
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) begin
                n_term++;
                chk("ack_err_excl", 64'(wb_ack_o & wb_err_o), 64'(0));
                chk("term_with_cyc", 64'(wb_cyc_i), 64'(1));
                if (rsp_q.size() == 0) begin
                    chk("unexpected_term", 64'({wb_ack_o, wb_err_o}), 64'(0));
                end else begin
                    e = rsp_q.pop_front();
                    chk("term_kind",  64'({wb_ack_o, wb_err_o}), 64'({!e.is_err, e.is_err}));
                    chk("term_cycle", 64'(cyc_n), 64'(e.at));
                    if (e.is_rd) chk("rd_data", 64'(wb_dat_o), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          t0;
        int unsigned c0;
        logic        w;
        wb_rst_i = 1'b1; sdr_init_done = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst0");
        @(posedge clk); #1;
        wb_rst_i = 1'b0;

        // No accept while SDRAM init is pending, then request one cycle after init
        wb_start(1'b1, 26'h100, 4'hF, 32'hA5A5_0001, 1'b1);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (app_req || wb_ack_o || wb_err_o) n++;
        end
        chk("t1_blocked", 64'(n), 64'(0));
        @(posedge clk); #1;
        sdr_init_done = 1'b1;
        @(negedge clk);
        chk("t1_req_early", 64'(app_req), 64'(0));
        @(negedge clk);
        chk("t1_req_next", 64'(app_req), 64'(1));
        wb_wait_term();
        wb_end();

        wb_start(1'b1, 26'h10, 4'b0011, 32'hDEAD_BEEF, 1'b1);
        wb_wait_term();
        chk("t2_ack", 64'(wb_ack_o), 64'(1));
        wb_end();

        use_fix_rd = 1'b1; fix_rd_data = 32'h1234_5678;
        wb_start(1'b0, 26'h40, 4'hF, 32'h0, 1'b1);
        wb_wait_term();
        chk("t3_dat", 64'(wb_dat_o), 64'(32'h1234_5678));
        wb_end();
        use_fix_rd = 1'b0;

        // Core never acks: request held for TIMEOUT cycles, then one err
        core_en = 1'b0;
        wb_start(1'b1, 26'h200, 4'hF, 32'h1, 1'b0);
        n = 0;
        while (!app_req && n < 20) begin @(negedge clk); n++; end
        c0 = cyc_n;
        rsp_q.push_back('{1'b1, 1'b0, 32'h0, c0 + TMO});
        n = 0;
        while (app_req && n < 100) begin n++; @(negedge clk); end
        chk("t4_req_cycles", 64'(n), 64'(TMO));
        chk("t4_err", 64'(wb_err_o), 64'(1));
        wb_end();
        core_en = 1'b1;
        repeat (3) @(posedge clk);

        // Master aborts during RDATA: late read data must not terminate
        fix_data_dly = 5;
        wb_start(1'b0, 26'h80, 4'hF, 32'h0, 1'b1);
        wait_req_accepted();
        wb_end();
        t0 = n_term;
        repeat (20) @(negedge clk);
        chk("t5_no_term", 64'(n_term - t0), 64'(0));
        fix_data_dly = -1;
        wb_start(1'b0, 26'h84, 4'hF, 32'h0, 1'b1);
        wb_wait_term();
        chk("t5_next_ack", 64'(wb_ack_o), 64'(1));
        wb_end();

        // Reset while waiting for write data
        fix_data_dly = 20;
        wb_start(1'b1, 26'h300, 4'b0101, 32'hCAFE_F00D, 1'b1);
        wait_req_accepted();
        @(posedge clk); #1;
        wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst_cnt++;
        @(negedge clk);
        @(negedge clk);
        check_reset("rst_mid");
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        fix_data_dly = -1;
        repeat (30) @(posedge clk);

        #1;
        wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_cyc_i = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (app_req || wb_ack_o || wb_err_o) n++;
        end
        chk("t6_stb_no_cyc", 64'(n), 64'(0));
        @(posedge clk); #1;
        wb_stb_i = 1'b0;

        repeat (40) begin
            w = 1'($urandom_range(1));
            wb_start(w, 26'($urandom), 4'($urandom), $urandom, 1'b1);
            wb_wait_term();
            chk("rnd_ack", 64'(wb_ack_o), 64'(1));
            wb_end();
            repeat ($urandom_range(2)) @(posedge clk);
        end

        repeat (5) @(negedge clk);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        chk("req_q_empty", 64'(req_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
